uart_tx: RTL and testbench

Serial UART transmitter: the transmit-side counterpart of the design's UART receiver, sharing its bit timing (`CLKS_PER_BIT`) and frame format. It takes parallel words over a valid/ready handshake and shifts them out LSB-first as start bit, data bits, optional parity and stop bit(s). A one-word holding register lets the next word be accepted while the current frame is on the line, so frames go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_cnt.sv | 46 ++++
 rtl/uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose: UART constants and helpers shared by the transmitter and the receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: 3-bit FSM state encodings, parity mode constants and a parity helper.
package uart_pkg;

    // FSM state encodings; the receiver uses the same names.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity modes selected by the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Turns the XOR-reduction of a data word into the line parity bit.
    function automatic logic parity_calc(input logic word_xor, input int mode);
        return (mode == PARITY_ODD) ? ~word_xor : word_xor;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Purpose: bit-period counter; tick_o marks the last clock of every serial bit.
// Latency: tick_o is combinational from the count register; first tick CLKS_PER_BIT-1 cycles after clear drops.
// Backpressure: none; free-running while clear_i is low.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset
//   clear_i - holds the count at 0 (asserted while the transmitter is idle)
//   tick_o  - high on the last cycle of each bit period
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1000,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// Purpose: UART transmitter, LSB-first: start, DATA_LEN data bits, optional parity, 1 or 2 stop bits.
// Latency: start bit is on tx_o the cycle after the accepting edge; frames run back-to-back.
// Backpressure: ready_o drops while the one-word holding register is full.
//
// Ports:
//   clk_i, rst_i  - clock and synchronous active-high reset
//   data_i        - word to send, taken when data_valid_i && ready_o
//   data_valid_i  - sender has a word
//   ready_o       - holding register empty (registered)
//   tx_o          - serial line, idles high (registered)
//   busy_o        - FSM is not idle
//   done_strb_o   - one-cycle pulse once the last stop bit has been sent
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DATA_LEN     = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_LEN-1:0] data_i,
    input  logic                data_valid_i,
    output logic                ready_o,
    output logic                tx_o,
    output logic                busy_o,
    output logic                done_strb_o
);

    localparam int BIT_W = $clog2(DATA_LEN + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

    logic [2:0]          state_q,     state_d;
    logic [DATA_LEN-1:0] shift_q,     shift_d;
    logic [DATA_LEN-1:0] hold_q,      hold_d;
    logic                hold_full_q, hold_full_d;
    logic                par_q,       par_d;
    logic [BIT_W-1:0]    bit_idx_q,   bit_idx_d;
    logic                stop_idx_q,  stop_idx_d;
    logic                tx_q,        tx_d;
    logic                ready_q,     ready_d;
    logic                done_q,      done_d;

    logic                accept;
    logic                in_idle;
    logic                state_legal;
    logic                tick;
    logic                last_stop;
    logic                frame_end;
    logic                load_en;
    logic [DATA_LEN-1:0] load_src;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(in_idle),
        .tick_o (tick)
    );

    assign accept      = data_valid_i && ready_q;
    assign in_idle     = (state_q == ST_IDLE);
    assign state_legal = (state_q == ST_IDLE)   || (state_q == ST_START) ||
                         (state_q == ST_DATA)   || (state_q == ST_PARITY) ||
                         (state_q == ST_STOP);
    // With one stop bit the index never advances, so the first stop bit is the last.
    assign last_stop   = (STOP_BITS == 2) ? stop_idx_q : 1'b1;
    assign frame_end   = (state_q == ST_STOP) && tick && last_stop;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        load_en     = 1'b0;
        load_src    = data_i;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            // Drain the held word: next start bit follows immediately.
                            load_en     = 1'b1;
                            load_src    = hold_q;
                            hold_full_d = 1'b0;
                            ready_d     = 1'b1;
                            state_d     = ST_START;
                        end else if (accept) begin
                            // Holding register is empty, so a word offered on the
                            // closing edge goes straight to the shifter; parking it
                            // would leave it stranded once the FSM went idle.
                            load_en = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                hold_full_d = 1'b0;
                ready_d     = 1'b1;
            end
        endcase

        // Words accepted mid-frame wait in the holding register.
        if (accept && state_legal && !in_idle && !frame_end) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
            ready_d     = 1'b0;
        end

        if (load_en) begin
            shift_d   = load_src;
            par_d     = parity_calc(^load_src, PARITY);
            bit_idx_d = '0;
        end

        // tx follows the state being entered so the line changes on the same edge.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign ready_o     = ready_q;
    assign tx_o        = tx_q;
    assign busy_o      = !in_idle;
    assign done_strb_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: bench for uart_tx over five parameter sets, each with a cycle-level line model.
// Latency: n/a.
// Backpressure: stimulus honours ready_o as predicted by the model.
module tb_uart_tx;

    localparam int NCFG = 5;
    localparam int CPB_T [NCFG] = '{4, 4, 4, 4, 1000};
    localparam int DL_T  [NCFG] = '{8, 8, 8, 8, 5};
    localparam int PAR_T [NCFG] = '{0, 1, 2, 1, 0};
    localparam int STB_T [NCFG] = '{1, 1, 1, 2, 1};

    typedef struct packed {
        logic b;
        logic last;
    } cell_t;

    logic            clk = 1'b0;
    logic [NCFG-1:0] rst_v;
    logic [NCFG-1:0] vld_v;
    logic [7:0]      data_v [NCFG];
    logic [NCFG-1:0] tx_w, busy_w, ready_w, done_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t got=%0h exp=%0h", nm, g, $time, got, exp);
        end
    endtask

    // Each configuration: DUT plus a model that expands every accepted word into
    // its per-cycle line values and replays them.
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int CPB = CPB_T[g];
        localparam int DL  = DL_T[g];
        localparam int PAR = PAR_T[g];
        localparam int STB = STB_T[g];
        localparam int NB  = 1 + DL + ((PAR != 0) ? 1 : 0) + STB;
        localparam int FL  = NB * CPB;

        uart_tx #(
            .CLKS_PER_BIT(CPB),
            .DATA_LEN    (DL),
            .PARITY      (PAR),
            .STOP_BITS   (STB)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst_v[g]),
            .data_i      (data_v[g][DL-1:0]),
            .data_valid_i(vld_v[g]),
            .ready_o     (ready_w[g]),
            .tx_o        (tx_w[g]),
            .busy_o      (busy_w[g]),
            .done_strb_o (done_w[g])
        );

        cell_t q[$];
        logic  exp_tx    = 1'b1;
        logic  exp_busy  = 1'b0;
        logic  exp_ready = 1'b1;
        logic  exp_done  = 1'b0;
        bit    armed     = 1'b0;

        always @(posedge clk) begin
            logic       popped_last;
            logic [7:0] w;
            logic       pb;
            logic       b;
            if (rst_v[g]) begin
                q.delete();
                exp_done  = 1'b0;
                exp_ready = 1'b1;
                armed     = 1'b1;
            end else begin
                popped_last = 1'b0;
                if (q.size() > 0) begin
                    popped_last = q[0].last;
                    void'(q.pop_front());
                end
                if (vld_v[g] && exp_ready) begin
                    w  = data_v[g] & 8'((1 << DL) - 1);
                    pb = ^w;
                    if (PAR == 2) pb = ~pb;
                    for (int p = 0; p < NB; p++) begin
                        if (p == 0)                          b = 1'b0;
                        else if (p <= DL)                    b = w[p-1];
                        else if (PAR != 0 && p == DL + 1)    b = pb;
                        else                                 b = 1'b1;
                        for (int c = 0; c < CPB; c++)
                            q.push_back(cell_t'{b: b, last: (p == NB - 1 && c == CPB - 1)});
                    end
                end
                exp_done  = popped_last;
                // More than one frame's worth queued means a word sits in holding.
                exp_ready = (q.size() <= FL);
            end
            exp_tx   = (q.size() > 0) ? q[0].b : 1'b1;
            exp_busy = (q.size() > 0);
        end

        always @(negedge clk) begin
            if (armed) begin
                chk("tx",    g, tx_w[g],    exp_tx);
                chk("busy",  g, busy_w[g],  exp_busy);
                chk("ready", g, ready_w[g], exp_ready);
                chk("done",  g, done_w[g],  exp_done);
            end
        end
    end

    // Sends one word from idle and pins each line bit (mid-bit) and the done pulse.
    task automatic frame_check(input int g, input logic [7:0] w, input int nbits,
                               input logic [11:0] exp_bits, input int cpb);
        @(negedge clk);
        data_v[g] = w;
        vld_v[g]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_v[g] = 1'b0;
        for (int k = 0; k <= nbits * cpb; k++) begin
            if (k > 0) @(negedge clk);
            if (k % cpb == cpb / 2) chk("lit_bit", g, tx_w[g], exp_bits[k / cpb]);
            if (k == nbits * cpb - 1) chk("lit_done_early", g, done_w[g], 1'b0);
            if (k == nbits * cpb) begin
                chk("lit_done", g, done_w[g], 1'b1);
                chk("lit_busy_end", g, busy_w[g], 1'b0);
            end
        end
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy_w[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", g, busy_w[g], 1'b0);
    endtask

    task automatic back_to_back(input int g);
        @(negedge clk);
        data_v[g] = 8'h55;
        vld_v[g]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_v[g] = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        data_v[g] = 8'h3C;
        chk("b2b_ready_low", g, ready_w[g], 1'b0);
        for (int k = 2; k <= 41; k++) begin
            @(negedge clk);
            if (k == 39) begin
                chk("b2b_stop", g, tx_w[g], 1'b1);
                chk("b2b_held_off", g, ready_w[g], 1'b0);
            end
            if (k == 40) begin
                chk("b2b_start2", g, tx_w[g], 1'b0);
                chk("b2b_ready_rise", g, ready_w[g], 1'b1);
                chk("b2b_done1", g, done_w[g], 1'b1);
            end
            if (k == 41) chk("b2b_third_taken", g, ready_w[g], 1'b0);
        end
        vld_v[g] = 1'b0;
        wait_idle(g, 3 * 40 + 10);
    endtask

    task automatic reset_mid(input int g);
        int zeros = 0;
        int dones = 0;
        @(negedge clk);
        data_v[g] = 8'h3C;
        vld_v[g]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_v[g] = 8'h81;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) vld_v[g] = 1'b0;
        end
        // cycle 17: data bit 3 on the line, a word pending
        chk("rst_pending", g, ready_w[g], 1'b0);
        rst_v[g] = 1'b1;
        @(negedge clk);
        chk("rst_tx", g, tx_w[g], 1'b1);
        chk("rst_ready", g, ready_w[g], 1'b1);
        chk("rst_busy", g, busy_w[g], 1'b0);
        rst_v[g] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!tx_w[g]) zeros++;
            if (done_w[g]) dones++;
        end
        chk("rst_no_frame", g, zeros, 0);
        chk("rst_no_done", g, dones, 0);
    endtask

    task automatic run_random(input int g, input int ncyc, input int drain);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            vld_v[g]  = ($urandom_range(0, 3) != 0);
            data_v[g] = 8'($urandom);
            rst_v[g]  = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        vld_v[g] = 1'b0;
        rst_v[g] = 1'b0;
        wait_idle(g, drain);
    endtask

    initial begin
        #(1_500_000 * 10);
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_v = '1;
        vld_v = '0;
        for (int g = 0; g < NCFG; g++) data_v[g] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            chk("reset_tx", g, tx_w[g], 1'b1);
            chk("reset_ready", g, ready_w[g], 1'b1);
            chk("reset_busy", g, busy_w[g], 1'b0);
            chk("reset_done", g, done_w[g], 1'b0);
        end
        rst_v = '0;

        frame_check(0, 8'hA5, 10, 12'b000_1101001010, 4);
        frame_check(1, 8'h07, 11, 12'b0_11000001110, 4);
        frame_check(2, 8'h07, 11, 12'b0_10000001110, 4);
        frame_check(3, 8'hA5, 12, 12'b110101001010, 4);
        back_to_back(0);
        reset_mid(1);
        for (int g = 0; g < 4; g++) run_random(g, 1500, 3 * 48 + 10);
        frame_check(4, 8'h1F, 7, 12'b00000_1111110, 1000);
        run_random(4, 16000, 2 * 7000 + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
